// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU.
package alu_pkg;

  // Widest datapath the saturating helper can handle.
  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_XOR    = 4'd2,
    OP_RED    = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_ROR    = 4'd6,
    OP_PADDSB = 4'd7,
    OP_LW     = 4'd8,
    OP_SW     = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SW;
  endfunction

  // Signed add/subtract of sign-extended operands, clamped to the range of a
  // w-bit two's-complement number. The caller truncates the result to w bits.
  function automatic logic signed [MAX_W-1:0] sat_add(
    input logic signed [MAX_W-1:0] x,
    input logic signed [MAX_W-1:0] y,
    input logic                    sub,
    input int unsigned             w
  );
    logic signed [MAX_W:0] s;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    s  = sub ? ((MAX_W+1)'(x) - (MAX_W+1)'(y)) : ((MAX_W+1)'(x) + (MAX_W+1)'(y));
    hi = ((MAX_W+1)'(1) <<< (w - 1)) - (MAX_W+1)'(1);
    lo = -hi - (MAX_W+1)'(1);
    if (s > hi) begin
      return MAX_W'(hi);
    end else if (s < lo) begin
      return MAX_W'(lo);
    end
    return MAX_W'(s);
  endfunction

endpackage

// File: rtl/alu_seq_shift_unit.sv
// Iterative shifter: moves the working value by up to SHIFT_STEP positions per
// cycle until the requested amount is consumed.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 1,
  localparam int SHW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   imm,
  output logic             done,
  output logic [WIDTH-1:0] next_val
);

  localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

  logic [SHW-1:0]   rem_q, rem_d, step;
  logic [WIDTH-1:0] work_q, work_d, shifted;
  alu_op_e          op_q, op_d;
  logic             active_q, active_d;

  // One step of the selected shift on the working value.
  always_comb begin
    step    = (rem_q > STEP) ? STEP : rem_q;
    shifted = work_q;
    case (op_q)
      OP_SLL:  shifted = work_q << step;
      OP_SRA:  shifted = $signed(work_q) >>> step;
      OP_ROR:  shifted = (work_q >> step) | (work_q << (WIDTH - int'(step)));
      default: shifted = work_q;
    endcase
  end

  // The step taken this cycle is the last one when the remainder fits in it.
  assign done     = active_q && (rem_q <= STEP);
  assign next_val = shifted;

  // Load on start, otherwise advance while active.
  always_comb begin
    rem_d    = rem_q;
    work_d   = work_q;
    op_d     = op_q;
    active_d = active_q;
    if (start) begin
      rem_d    = imm;
      work_d   = a;
      op_d     = op;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d    = rem_q - step;
      work_d   = shifted;
      active_d = !done;
    end
  end

  // Shift state registers; reset aborts any shift in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      work_q   <= '0;
      op_q     <= OP_ADD;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      work_q   <= work_d;
      op_q     <= op_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU with saturating arithmetic, a flag register and an
// iterative shifter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 1,
  localparam int SHW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             err,
  output logic             busy
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] add_sat, sub_sat, sum_raw, diff_raw;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] red_res, pad_res, addr_res, alu_res;
  alu_flags_t       alu_flags;
  logic             sh_start, sh_done;
  logic [WIDTH-1:0] sh_next;

  assign add_sat  = WIDTH'(sat_add(MAX_W'($signed(a)), MAX_W'($signed(b)), 1'b0, WIDTH));
  assign sub_sat  = WIDTH'(sat_add(MAX_W'($signed(a)), MAX_W'($signed(b)), 1'b1, WIDTH));
  assign sum_raw  = a + b;
  assign diff_raw = a - b;
  assign add_v    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_raw[WIDTH-1] != a[WIDTH-1]);
  assign sub_v    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_raw[WIDTH-1] != a[WIDTH-1]);
  assign addr_res = (a & ~WIDTH'(1)) + b;

  // Byte reduction and saturating nibble lanes.
  always_comb begin
    red_res = '0;
    pad_res = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      red_res = red_res + WIDTH'($signed(a[8*i +: 8])) + WIDTH'($signed(b[8*i +: 8]));
    end
    for (int i = 0; i < WIDTH / 4; i++) begin
      pad_res[4*i +: 4] = 4'(sat_add(MAX_W'($signed(a[4*i +: 4])),
                                     MAX_W'($signed(b[4*i +: 4])), 1'b0, 4));
    end
  end

  // Single-cycle result and the flags each single-cycle opcode leaves behind.
  always_comb begin
    alu_res   = '0;
    alu_flags = flags_q;
    case (alu_op_e'(opcode))
      OP_ADD: begin
        alu_res   = add_sat;
        alu_flags = '{z: (add_sat == '0), n: add_sat[WIDTH-1], v: add_v};
      end
      OP_SUB: begin
        alu_res   = sub_sat;
        alu_flags = '{z: (sub_sat == '0), n: sub_sat[WIDTH-1], v: sub_v};
      end
      OP_XOR: begin
        alu_res     = a ^ b;
        alu_flags.z = ((a ^ b) == '0);
      end
      OP_RED:       alu_res = red_res;
      OP_PADDSB:    alu_res = pad_res;
      OP_LW, OP_SW: alu_res = addr_res;
      default:      alu_res = '0;
    endcase
  end

  alu_shift_unit #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .start    (sh_start),
    .op       (alu_op_e'(opcode)),
    .a        (a),
    .imm      (imm),
    .done     (sh_done),
    .next_val (sh_next)
  );

  // Next-state, result, flag and error logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    sh_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
          if (!is_legal(opcode)) begin
            result_d = '0;
            err_d    = 1'b1;
          end else if (is_shift(opcode)) begin
            if (imm == '0) begin
              result_d  = a;
              flags_d.z = (a == '0);
            end else begin
              sh_start = 1'b1;
              state_d  = ST_BUSY;
            end
          end else begin
            result_d = alu_res;
            flags_d  = alu_flags;
          end
        end
      end
      ST_BUSY: begin
        if (sh_done) begin
          result_d  = sh_next;
          flags_d.z = (sh_next == '0);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural registers; reset aborts whatever is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16, SHIFT_STEP=1).
module tb_alu_seq;

  localparam int W    = 16;
  localparam int STEP = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   imm = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_v, err, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .err(err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference behaviour. upd: 0 = flags untouched, 1 = Z only, 2 = Z/N/V.
  function automatic void model_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                   input logic [3:0] sh, output logic [15:0] r, output int upd,
                                   output logic v, output logic e);
    int s;
    logic signed [15:0] sx;
    r = '0; upd = 0; v = 1'b0; e = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        if (op == 4'd0) s = int'($signed(x)) + int'($signed(y));
        else            s = int'($signed(x)) - int'($signed(y));
        if (s > 32767)       begin r = 16'h7FFF; v = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; v = 1'b1; end
        else                 r = 16'(s);
        upd = 2;
      end
      4'd2: begin r = x ^ y; upd = 1; end
      4'd3: begin
        s = int'($signed(x[7:0])) + int'($signed(x[15:8])) +
            int'($signed(y[7:0])) + int'($signed(y[15:8]));
        r = 16'(s);
      end
      4'd4: begin r = x << sh; upd = 1; end
      4'd5: begin sx = x; r = sx >>> sh; upd = 1; end
      4'd6: begin r = 16'({x, x} >> sh); upd = 1; end
      4'd7: begin
        for (int i = 0; i < 4; i++) begin
          s = int'($signed(x[4*i +: 4])) + int'($signed(y[4*i +: 4]));
          if (s > 7)  s = 7;
          if (s < -8) s = -8;
          r[4*i +: 4] = 4'(s);
        end
      end
      4'd8, 4'd9: r = (x & 16'hFFFE) + y;
      default: e = 1'b1;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [3:0] sh);
    if ((op >= 4'd4) && (op <= 4'd6) && (sh != 0)) return (int'(sh) + STEP - 1) / STEP + 1;
    return 1;
  endfunction

  function automatic logic [2:0] model_flags(input int upd, input logic [15:0] r, input logic v,
                                             input logic [2:0] cur);
    if (upd == 2) return {r == 16'h0, r[15], v};
    if (upd == 1) return {r == 16'h0, cur[1:0]};
    return cur;
  endfunction

  // Model of the transaction in flight: 0 = waiting for work, 1 = computing,
  // 2 = result on offer.
  int          m_phase = 0;
  int          m_wait  = 0;
  logic [15:0] m_res   = '0;
  logic [2:0]  m_flags = '0;
  logic        m_err   = 1'b0;
  logic [15:0] p_res, q_res = '0;
  int          p_upd, q_upd = 0, p_lat;
  logic        p_v, p_e, q_v = 1'b0, q_e = 1'b0;

  always_comb begin
    model_op(opcode, a, b, imm, p_res, p_upd, p_v, p_e);
    p_lat = model_lat(opcode, imm);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_wait <= 0; m_res <= '0; m_flags <= '0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_err <= 1'b0;
          q_res <= p_res; q_upd <= p_upd; q_v <= p_v; q_e <= p_e;
          if (p_lat == 1) begin
            m_phase <= 2; m_res <= p_res; m_err <= p_e;
            m_flags <= model_flags(p_upd, p_res, p_v, m_flags);
          end else begin
            m_phase <= 1; m_wait <= p_lat - 1;
          end
        end
        1: if (m_wait == 1) begin
          m_phase <= 2; m_res <= q_res; m_err <= q_e;
          m_flags <= model_flags(q_upd, q_res, q_v, m_flags);
        end else begin
          m_wait <= m_wait - 1;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      chk("flags", {flag_z, flag_n, flag_v}, m_flags);
      chk("err", err, m_err);
      if (m_phase == 2) chk("result", result, m_res);
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [3:0] iimm, input int hold, output logic [15:0] res,
                       output int lat);
    opcode = op; a = ia; b = ib; imm = iimm; in_valid = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) chk("timeout_out_valid", out_valid, 1);
    res = result;
    $display("op=%0h a=%04h b=%04h imm=%0d -> result=%04h zvn=%b%b%b err=%b lat=%0d",
             op, ia, ib, iimm, result, flag_z, flag_v, flag_n, err, lat);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [15:0] r;
  int          lat;

  initial begin
    #1 rst = 1'b1;
    #11;
    chk("rst_result", result, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {flag_z, flag_n, flag_v}, 0);
    chk("rst_err", err, 0);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    do_op(4'd0, 16'h7FFF, 16'h0001, 4'd0, 0, r, lat);
    chk("add_sat_res", r, 16'h7FFF); chk("add_sat_lat", lat, 1);
    chk("add_sat_znv", {flag_z, flag_n, flag_v}, 3'b001);
    do_op(4'd7, 16'h7777, 16'h1111, 4'd0, 0, r, lat);
    chk("paddsb_res", r, 16'h7777); chk("paddsb_znv", {flag_z, flag_n, flag_v}, 3'b001);
    do_op(4'd1, 16'h0005, 16'h0005, 4'd0, 0, r, lat);
    chk("sub_zero_res", r, 16'h0000); chk("sub_zero_znv", {flag_z, flag_n, flag_v}, 3'b100);
    do_op(4'hF, 16'h1234, 16'h5678, 4'd3, 0, r, lat);
    chk("illegal_res", r, 0); chk("illegal_err", err, 1); chk("illegal_lat", lat, 1);
    chk("illegal_znv", {flag_z, flag_n, flag_v}, 3'b100);
    do_op(4'd4, 16'h0001, 16'h0000, 4'd15, 0, r, lat);
    chk("sll15_res", r, 16'h8000); chk("sll15_lat", lat, 16); chk("sll15_err", err, 0);
    do_op(4'd5, 16'h8000, 16'h0000, 4'd4, 0, r, lat);
    chk("sra4_res", r, 16'hF800); chk("sra4_lat", lat, 5);
    do_op(4'd6, 16'h0001, 16'h0000, 4'd1, 0, r, lat);
    chk("ror1_res", r, 16'h8000); chk("ror1_lat", lat, 2);
    do_op(4'd4, 16'h1234, 16'h0000, 4'd0, 0, r, lat);
    chk("sll0_res", r, 16'h1234); chk("sll0_lat", lat, 1);
    do_op(4'd3, 16'h0102, 16'h0304, 4'd0, 0, r, lat);
    chk("red_res", r, 16'h000A);
    do_op(4'd8, 16'h1001, 16'h0004, 4'd0, 0, r, lat);
    chk("lw_res", r, 16'h1004);
    do_op(4'd2, 16'h00FF, 16'h0F0F, 4'd0, 3, r, lat);
    chk("xor_bp_res", r, 16'h0FF0); chk("xor_bp_held", result, 16'h0FF0);
    do_op(4'd1, 16'h8000, 16'h0001, 4'd0, 0, r, lat);
    chk("sub_negsat_res", r, 16'h8000); chk("sub_negsat_znv", {flag_z, flag_n, flag_v}, 3'b011);

    // Reset in the middle of a long shift.
    opcode = 4'd4; a = 16'h0001; imm = 4'd10; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_flags", {flag_z, flag_n, flag_v}, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_in_ready", in_ready, 1);
    do_op(4'd0, 16'h0002, 16'h0003, 4'd0, 0, r, lat);
    chk("after_rst_add", r, 16'h0005); chk("after_rst_lat", lat, 1);

    for (int i = 0; i < 150; i++) begin
      do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), r, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
